// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package mdu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  // Counter must hold values up to WIDTH.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One combinational iteration of the multiply/divide datapath.
// acc is the upper half of the working pair, opr the lower half.
//  multiply: opr holds the multiplier; conditional add then right shift.
//  divide:   acc is the partial remainder, opr shifts dividend out / quotient in.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             op_div_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] opr_i,
  input  logic [WIDTH-1:0] mag_b_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] opr_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Select shift-add or trial-subtract for this iteration.
  always_comb begin
    sum     = {1'b0, acc_i} + (opr_i[0] ? {1'b0, mag_b_i} : '0);
    shifted = {acc_i, opr_i[WIDTH-1]};
    diff    = shifted - {1'b0, mag_b_i};
    acc_o   = sum[WIDTH:1];
    opr_o   = {sum[0], opr_i[WIDTH-1:1]};
    if (op_div_i == OP_DIV) begin
      // Partial remainder is always < divisor, so shifted fits WIDTH+1 bits.
      if (shifted >= {1'b0, mag_b_i}) begin
        acc_o = diff[WIDTH-1:0];
        opr_o = {opr_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = shifted[WIDTH-1:0];
        opr_o = {opr_i[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed/unsigned multiply/divide with HI/LO result registers.
// Optional macro MDU_HILO_WRITE_EN adds direct HI/LO write ports (MTHI/MTLO).
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MDU_HILO_WRITE_EN
  input  logic [1:0]       hilo_we,
  input  logic [WIDTH-1:0] hilo_wdata,
`endif
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q, opr_q, mag_b_q;
  logic             op_div_q, neg_q, rneg_q;
  logic             busy_q, done_q, dz_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH-1:0]   acc_d, opr_d;
  logic [2*WIDTH-1:0] prod;

  // Operand magnitudes; raw operands in unsigned mode.
  always_comb begin
    abs_a = (is_signed && a[WIDTH-1]) ? -a : a;
    abs_b = (is_signed && b[WIDTH-1]) ? -b : b;
    prod  = {acc_q, opr_q};
  end

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .op_div_i (op_div_q),
    .acc_i    (acc_q),
    .opr_i    (opr_q),
    .mag_b_i  (mag_b_q),
    .acc_o    (acc_d),
    .opr_o    (opr_d)
  );

  // Control FSM, iteration counter, datapath and HI/LO registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opr_q    <= '0;
      mag_b_q  <= '0;
      op_div_q <= OP_MUL;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
`ifdef MDU_HILO_WRITE_EN
      // Direct writes only land while idle; the FIX edge is busy so results win.
      if (!busy_q) begin
        if (hilo_we[1]) hi_q <= hilo_wdata;
        if (hilo_we[0]) lo_q <= hilo_wdata;
      end
`endif
      case (state_q)
        IDLE: begin
          if (start) begin
            if (op_div == OP_DIV && b == '0) begin
              // Trap immediately; HI/LO left untouched.
              done_q <= 1'b1;
              dz_q   <= 1'b1;
            end else begin
              state_q  <= RUN;
              busy_q   <= 1'b1;
              cnt_q    <= '0;
              acc_q    <= '0;
              opr_q    <= abs_a;
              mag_b_q  <= abs_b;
              op_div_q <= op_div;
              neg_q    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
              rneg_q   <= is_signed & a[WIDTH-1];
            end
          end
        end
        RUN: begin
          acc_q <= acc_d;
          opr_q <= opr_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_q <= FIX;
        end
        FIX: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          if (op_div_q == OP_DIV) begin
            // Quotient truncates toward zero; remainder follows dividend sign.
            lo_q <= neg_q  ? -opr_q : opr_q;
            hi_q <= rneg_q ? -acc_q : acc_q;
          end else begin
            {hi_q, lo_q} <= neg_q ? -prod : prod;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit at WIDTH=32.
module tb_mult_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, op_div, is_signed;
  logic [W-1:0] a, b;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;
`ifdef MDU_HILO_WRITE_EN
  logic [1:0]   hilo_we = 2'b00;
  logic [W-1:0] hilo_wdata = '0;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int cyc;
  logic seen;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op_div    (op_div),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
`ifdef MDU_HILO_WRITE_EN
    .hilo_we   (hilo_we),
    .hilo_wdata(hilo_wdata),
`endif
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .hi        (hi),
    .lo        (lo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present an operation at a negedge; returns #1 after the accept edge.
  task automatic launch(input logic d, input logic s, input logic [W-1:0] aa, input logic [W-1:0] bb);
    @(negedge clk);
    start = 1'b1; op_div = d; is_signed = s; a = aa; b = bb;
    @(posedge clk); #1;
    start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1357_9BDF; op_div = ~d; is_signed = ~s;
  endtask

  // Counts edges until done is seen at a negedge; -1 on timeout.
  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); @(negedge clk);
      if (done) begin n = i; break; end
    end
  endtask

  task automatic run_op(input string tag, input logic d, input logic s,
                        input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic [W-1:0] eh, input logic [W-1:0] el);
    int n;
    launch(d, s, aa, bb);
    chk({tag, ".busy"}, 64'(busy), 64'd1);
    wait_done(n);
    chk({tag, ".lat"}, 64'(n), 64'd33);
    chk({tag, ".hi"}, 64'(hi), 64'(eh));
    chk({tag, ".lo"}, 64'(lo), 64'(el));
    chk({tag, ".dz"}, 64'(div_zero), 64'd0);
    chk({tag, ".busy_end"}, 64'(busy), 64'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op_div = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    @(negedge clk);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.dz",   64'(div_zero), 64'd0);
    chk("rst.hi",   64'(hi), 64'd0);
    chk("rst.lo",   64'(lo), 64'd0);
    reset = 1'b0;

    run_op("smul",   1'b0, 1'b1, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("umul",   1'b0, 1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("sdiv",   1'b1, 1'b1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("udiv",   1'b1, 1'b0, 32'hFFFF_FFF9,  32'd2,         32'h0000_0001, 32'h7FFF_FFFC);
    run_op("sdivmn", 1'b1, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("sdivnb", 1'b1, 1'b1, 32'd7,          32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("pre_dz", 1'b1, 1'b0, 32'd5,          32'd2,         32'h0000_0001, 32'h0000_0002);

    // Divide by zero: immediate done/div_zero, HI/LO kept.
    launch(1'b1, 1'b0, 32'd5, 32'd0);
    chk("dz.busy0", 64'(busy), 64'd0);
    @(negedge clk);
    chk("dz.done",  64'(done), 64'd1);
    chk("dz.flag",  64'(div_zero), 64'd1);
    chk("dz.hi",    64'(hi), 64'd1);
    chk("dz.lo",    64'(lo), 64'd2);
    @(negedge clk);
    chk("dz.pulse", 64'({done, div_zero}), 64'd0);

    // Start pulsed while busy is ignored.
    launch(1'b0, 1'b0, 32'd3, 32'd4);
    repeat (5) @(negedge clk);
    start = 1'b1; op_div = 1'b1; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    chk("ign.lat", 64'(cyc), 64'd28);
    chk("ign.hi",  64'(hi), 64'd0);
    chk("ign.lo",  64'(lo), 64'd12);

    // Back-to-back: start presented in the done cycle.
    start = 1'b1; op_div = 1'b0; is_signed = 1'b1; a = 32'hFFFF_FFFE; b = 32'hFFFF_FFFD;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b.busy", 64'(busy), 64'd1);
    wait_done(cyc);
    chk("b2b.lat", 64'(cyc), 64'd33);
    chk("b2b.hi",  64'(hi), 64'd0);
    chk("b2b.lo",  64'(lo), 64'd6);

    // Reset mid-operation aborts with no done.
    launch(1'b0, 1'b0, 32'd9, 32'd9);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rmid.busy", 64'(busy), 64'd0);
    chk("rmid.hi",   64'(hi), 64'd0);
    chk("rmid.lo",   64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("rmid.nodone", 64'(seen), 64'd0);
    chk("rmid.lo_kept", 64'(lo), 64'd0);

`ifdef MDU_HILO_WRITE_EN
    run_op("pre_wr", 1'b0, 1'b0, 32'd3, 32'd5, 32'd0, 32'd15);
    @(negedge clk);
    hilo_we = 2'b10; hilo_wdata = 32'h1234;
    @(negedge clk);
    hilo_we = 2'b00;
    chk("wr.hi", 64'(hi), 64'h1234);
    chk("wr.lo", 64'(lo), 64'd15);
    launch(1'b0, 1'b0, 32'd2, 32'd2);
    @(negedge clk);
    hilo_we = 2'b11; hilo_wdata = 32'h5555;
    @(negedge clk);
    hilo_we = 2'b00;
    chk("wrb.hi", 64'(hi), 64'h1234);
    chk("wrb.lo", 64'(lo), 64'd15);
    wait_done(cyc);
    chk("wrb.res", 64'(lo), 64'd4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
